id_ex_hazard_stage: RTL and testbench
=====================================

Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register plus stall/flush controller for the 5-stage RV32 core with CSR support.
- Sits between decode/register-file read (operands already passed through the forwarding unit) and the execute stage.
- Inserts bubbles for load-use hazards, because the forwarding path cannot forward a load result out of EX/MEM.
- Holds the front end during external memory waits and applies branch flushes, including flushes that arrive while held.

Parameters:
- XLEN, 32, datapath width.
- ALUOP_W, 5, width of the decoded ALU operation field.
- CNT_W, 32, width of the bubble performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- id_rs1, id_rs2, id_rs3  in  5 each  source register / CSR indices.
- id_use_r1, id_use_r2, id_use_r3  in  1 each  source-used flags.
- id_rd  in  5  destination register.
- id_rw, id_csrr  in  1 each  GPR write / CSR write flags.
- id_wbsel  in  2  writeback select; bit0=1 means load.
- id_aluop  in  ALUOP_W  decoded ALU operation.
- fwd_a, fwd_b, fwd_c  in  XLEN each  forwarded operands.
- ex_mem_rd  in  5  EX/MEM destination register.
- ex_mem_rw  in  1  EX/MEM GPR write flag.
- ex_mem_wbsel  in  2  EX/MEM writeback select.
- branch_flush  in  1  taken branch/jump resolved in EX.
- ext_stall  in  1  data/instruction memory busy.
- pc_hold  out  1  freeze PC and IF/ID.
- ifid_flush  out  1  clear IF/ID.
- ex_valid  out  1  EX instruction valid.
- ex_pc  out  XLEN  latched PC.
- ex_a, ex_b, ex_c  out  XLEN each  latched operands.
- ex_rd, ex_rs3  out  5 each  latched destination / CSR index.
- ex_rw, ex_csrr  out  1 each  latched write flags.
- ex_wbsel  out  2  latched writeback select.
- ex_aluop  out  ALUOP_W  latched ALU operation.
- bubble_cnt  out  CNT_W  count of inserted bubbles.

Behaviour:
- Reset (asynchronous, rstn=0):
  - All ex_* outputs are 0, with ex_valid=0.
  - bubble_cnt=0.
  - FSM goes to RUN.
  - pc_hold and ifid_flush are 0 during reset.
- Hazard terms (combinational):
  - m1 = id_use_r1 and rs1 != 0.
  - m2 = id_use_r2 and rs2 != 0.
  - hz_ex = id_valid and ex_valid and ex_wbsel[0] and ex_rw and ((m1 and rs1==ex_rd) or (m2 and rs2==ex_rd)).
  - hz_mem = id_valid and ex_mem_wbsel[0] and ex_mem_rw and ex_mem_rd != 0 and ((m1 and rs1==ex_mem_rd) or (m2 and rs2==ex_mem_rd)).
  - load_stall = hz_ex or hz_mem. A dependent instruction one slot behind a load therefore gets 2 bubbles; two slots behind gets 1.
  - CSR source rs3 never stalls.
- FSM states: RUN, HOLD, HOLD_FL.
- RUN:
  - ext_stall=1: go to HOLD, or HOLD_FL if branch_flush is also 1. Registers frozen, pc_hold=1.
  - else if branch_flush=1: ID/EX loads a bubble (ex_valid=0, ex_rw=0, ex_csrr=0), ifid_flush=1, pc_hold=0. Flush beats load_stall.
  - else if load_stall=1: ID/EX loads a bubble, pc_hold=1, bubble_cnt+1.
  - else: ID/EX captures all id_* and fwd_* inputs; ex_valid=id_valid.
- HOLD:
  - All registers frozen, pc_hold=1, ifid_flush=0.
  - branch_flush=1 while held: go to HOLD_FL.
  - ext_stall=0: go to RUN.
- HOLD_FL:
  - Frozen, pc_hold=1.
  - On ext_stall=0: perform the flush in that release cycle (bubble, ifid_flush=1), then go to RUN.
- A bubble clears only the control fields (valid/rw/csrr/wbsel). Data fields keep their previous values.
- bubble_cnt counts load-stall bubbles only, not flush bubbles. It wraps modulo 2^CNT_W.
- Reset asserted mid-stall discards any pending flush.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- ifid_flush is a single-cycle pulse.

Decomposition:
- Shared package core_pkg holds:
  - FSM state encoding (RUN=2'd0, HOLD=2'd1, HOLD_FL=2'd2).
  - WBSEL_LOAD_BIT=0.
  - The bubble control-field constant.
- One natural sub-module: load_use_detect (combinational hz_ex/hz_mem). The register and FSM stay in the top module.

Test Plan:
- Reset, then id_valid=1, rs1=3, fwd_a=0x1234, no hazards -> next edge ex_valid=1, ex_a=0x1234, pc_hold=0.
- ID/EX holds a load with rd=5; ID reads rs1=5 -> 2 cycles pc_hold=1 with ex_valid=0, bubble_cnt=2, then the instruction is captured.
- EX/MEM load with rd=7, ID uses rs2=7 -> 1 bubble, bubble_cnt=1. Repeat with rd=0 -> no stall.
- branch_flush=1 coincident with load_stall=1 -> ifid_flush=1, ex_valid=0, pc_hold=0, bubble_cnt unchanged.
- ext_stall=1 for 3 cycles with branch_flush pulsed in cycle 2 -> ex_* frozen and pc_hold=1 throughout; on release, ifid_flush=1 and ex_valid=0 for exactly 1 cycle.
- rstn pulled low in HOLD_FL -> outputs clear immediately; after release no flush pulse occurs.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the ID/EX hazard stage: FSM encoding, default widths
// and the control-field pattern written into ID/EX when a bubble is inserted.
package core_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int ALUOP_W_DEF = 5;
  localparam int CNT_W_DEF   = 32;

  localparam int WBSEL_LOAD_BIT = 0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    HOLD_FL = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic       valid;
    logic       rw;
    logic       csrr;
    logic [1:0] wbsel;
  } ex_ctrl_t;

  // Only control fields are cleared by a bubble; data fields keep their values.
  localparam ex_ctrl_t BUBBLE_CTRL = '{valid: 1'b0, rw: 1'b0, csrr: 1'b0, wbsel: 2'b00};

endpackage

// File: rtl/id_ex_hazard_stage_if.sv
// Bundle of decode-side inputs, hazard/control inputs and ID/EX outputs.
// master = decode/testbench side, slave = the ID/EX stage.
interface id_ex_hazard_stage_if #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 32
);
  logic               id_valid;
  logic [XLEN-1:0]    id_pc;
  logic [4:0]         id_rs1, id_rs2, id_rs3;
  logic               id_use_r1, id_use_r2, id_use_r3;
  logic [4:0]         id_rd;
  logic               id_rw, id_csrr;
  logic [1:0]         id_wbsel;
  logic [ALUOP_W-1:0] id_aluop;
  logic [XLEN-1:0]    fwd_a, fwd_b, fwd_c;
  logic [4:0]         ex_mem_rd;
  logic               ex_mem_rw;
  logic [1:0]         ex_mem_wbsel;
  logic               branch_flush;
  logic               ext_stall;
  logic               pc_hold;
  logic               ifid_flush;
  logic               ex_valid;
  logic [XLEN-1:0]    ex_pc;
  logic [XLEN-1:0]    ex_a, ex_b, ex_c;
  logic [4:0]         ex_rd, ex_rs3;
  logic               ex_rw, ex_csrr;
  logic [1:0]         ex_wbsel;
  logic [ALUOP_W-1:0] ex_aluop;
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rs3, id_use_r1, id_use_r2, id_use_r3,
    output id_rd, id_rw, id_csrr, id_wbsel, id_aluop, fwd_a, fwd_b, fwd_c,
    output ex_mem_rd, ex_mem_rw, ex_mem_wbsel, branch_flush, ext_stall,
    input  pc_hold, ifid_flush, ex_valid, ex_pc, ex_a, ex_b, ex_c, ex_rd, ex_rs3,
    input  ex_rw, ex_csrr, ex_wbsel, ex_aluop, bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rs3, id_use_r1, id_use_r2, id_use_r3,
    input  id_rd, id_rw, id_csrr, id_wbsel, id_aluop, fwd_a, fwd_b, fwd_c,
    input  ex_mem_rd, ex_mem_rw, ex_mem_wbsel, branch_flush, ext_stall,
    output pc_hold, ifid_flush, ex_valid, ex_pc, ex_a, ex_b, ex_c, ex_rd, ex_rs3,
    output ex_rw, ex_csrr, ex_wbsel, ex_aluop, bubble_cnt
  );
endinterface

// File: rtl/id_ex_hazard_stage_load_use_detect.sv
// Load-use hazard detection against the load in ID/EX and the load in EX/MEM.
// The CSR source index is deliberately not examined.
module load_use_detect (
  input  logic       id_valid,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_r1,
  input  logic       use_r2,
  input  logic       ex_valid,
  input  logic       ex_rw,
  input  logic       ex_load,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_rw,
  input  logic       ex_mem_load,
  input  logic [4:0] ex_mem_rd,
  output logic       hz_ex,
  output logic       hz_mem
);
  logic m1_s, m2_s;

  assign m1_s = use_r1 & (rs1 != 5'd0);
  assign m2_s = use_r2 & (rs2 != 5'd0);

  assign hz_ex  = id_valid & ex_valid & ex_load & ex_rw &
                  ((m1_s & (rs1 == ex_rd)) | (m2_s & (rs2 == ex_rd)));
  assign hz_mem = id_valid & ex_mem_load & ex_mem_rw & (ex_mem_rd != 5'd0) &
                  ((m1_s & (rs1 == ex_mem_rd)) | (m2_s & (rs2 == ex_mem_rd)));
endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use bubbles, external-stall hold and
// branch flushes, including a flush remembered while the pipe is held.
module id_ex_hazard_stage
  import core_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  id_ex_hazard_stage_if.slave  bus
);
  stage_state_t       state_r, state_nx_s;
  ex_ctrl_t           ctrl_r;
  logic [XLEN-1:0]    pc_r, a_r, b_r, c_r;
  logic [4:0]         rd_r, rs3_r;
  logic [ALUOP_W-1:0] aluop_r;
  logic [CNT_W-1:0]   cnt_r;

  logic hz_ex_s, hz_mem_s, load_stall_s;
  logic capture_s, bubble_s, count_s, pc_hold_s, ifid_flush_s;
  logic unused_s;

  assign unused_s = ^{bus.id_use_r3, bus.ex_mem_wbsel[1]};

  load_use_detect u_detect (
    .id_valid    (bus.id_valid),
    .rs1         (bus.id_rs1),
    .rs2         (bus.id_rs2),
    .use_r1      (bus.id_use_r1),
    .use_r2      (bus.id_use_r2),
    .ex_valid    (ctrl_r.valid),
    .ex_rw       (ctrl_r.rw),
    .ex_load     (ctrl_r.wbsel[WBSEL_LOAD_BIT]),
    .ex_rd       (rd_r),
    .ex_mem_rw   (bus.ex_mem_rw),
    .ex_mem_load (bus.ex_mem_wbsel[WBSEL_LOAD_BIT]),
    .ex_mem_rd   (bus.ex_mem_rd),
    .hz_ex       (hz_ex_s),
    .hz_mem      (hz_mem_s)
  );

  assign load_stall_s = hz_ex_s | hz_mem_s;

  // Next-state and per-cycle register action; flush outranks load stall.
  always_comb begin
    state_nx_s   = state_r;
    capture_s    = 1'b0;
    bubble_s     = 1'b0;
    count_s      = 1'b0;
    pc_hold_s    = 1'b0;
    ifid_flush_s = 1'b0;
    case (state_r)
      RUN: begin
        if (bus.ext_stall) begin
          pc_hold_s  = 1'b1;
          state_nx_s = bus.branch_flush ? HOLD_FL : HOLD;
        end else if (bus.branch_flush) begin
          bubble_s     = 1'b1;
          ifid_flush_s = 1'b1;
        end else if (load_stall_s) begin
          bubble_s  = 1'b1;
          count_s   = 1'b1;
          pc_hold_s = 1'b1;
        end else begin
          capture_s = 1'b1;
        end
      end
      HOLD: begin
        pc_hold_s = 1'b1;
        if (bus.branch_flush) begin
          state_nx_s = HOLD_FL;
        end else if (!bus.ext_stall) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = HOLD;
        end
      end
      HOLD_FL: begin
        // The pending flush is applied in the release cycle itself.
        if (!bus.ext_stall) begin
          bubble_s     = 1'b1;
          ifid_flush_s = 1'b1;
          state_nx_s   = RUN;
        end else begin
          pc_hold_s = 1'b1;
        end
      end
      default: begin
        state_nx_s = RUN;
      end
    endcase
  end

  // FSM state, ID/EX register and bubble counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= RUN;
      ctrl_r  <= BUBBLE_CTRL;
      pc_r    <= {XLEN{1'b0}};
      a_r     <= {XLEN{1'b0}};
      b_r     <= {XLEN{1'b0}};
      c_r     <= {XLEN{1'b0}};
      rd_r    <= 5'd0;
      rs3_r   <= 5'd0;
      aluop_r <= {ALUOP_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      if (capture_s) begin
        ctrl_r  <= '{valid: bus.id_valid, rw: bus.id_rw, csrr: bus.id_csrr, wbsel: bus.id_wbsel};
        pc_r    <= bus.id_pc;
        a_r     <= bus.fwd_a;
        b_r     <= bus.fwd_b;
        c_r     <= bus.fwd_c;
        rd_r    <= bus.id_rd;
        rs3_r   <= bus.id_rs3;
        aluop_r <= bus.id_aluop;
      end else if (bubble_s) begin
        ctrl_r <= BUBBLE_CTRL;
      end
      if (count_s) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Front-end controls are held low while reset is asserted.
  assign bus.pc_hold    = rstn & pc_hold_s;
  assign bus.ifid_flush = rstn & ifid_flush_s;
  assign bus.ex_valid   = ctrl_r.valid;
  assign bus.ex_rw      = ctrl_r.rw;
  assign bus.ex_csrr    = ctrl_r.csrr;
  assign bus.ex_wbsel   = ctrl_r.wbsel;
  assign bus.ex_pc      = pc_r;
  assign bus.ex_a       = a_r;
  assign bus.ex_b       = b_r;
  assign bus.ex_c       = c_r;
  assign bus.ex_rd      = rd_r;
  assign bus.ex_rs3     = rs3_r;
  assign bus.ex_aluop   = aluop_r;
  assign bus.bubble_cnt = cnt_r;
endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Scoreboard bench: each driven cycle pushes the outputs a behavioural model
// predicts; a negedge monitor pops and compares them against the DUT.
module tb_id_ex_hazard_stage;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  id_ex_hazard_stage_if bus ();
  id_ex_hazard_stage dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    bit        id_valid;
    bit [31:0] pc;
    bit [4:0]  rs1, rs2, rs3;
    bit        use_r1, use_r2, use_r3;
    bit [4:0]  rd;
    bit        rw, csrr;
    bit [1:0]  wbsel;
    bit [4:0]  aluop;
    bit [31:0] fa, fb, fc;
    bit [4:0]  mrd;
    bit        mrw;
    bit [1:0]  mwbsel;
    bit        flush, ext;
  } stim_t;

  // Architectural view of the EX-side latch plus the front-end hold bookkeeping.
  typedef struct {
    bit        ev, rw, csrr;
    bit [1:0]  wbsel;
    bit [31:0] pc, a, b, c;
    bit [4:0]  rd, rs3, aluop;
    bit [31:0] cnt;
    bit        held, pend;
  } model_t;

  typedef struct {
    bit     pc_hold, ifid_flush;
    model_t m;
  } exp_t;

  exp_t   q[$];
  model_t m;
  int     tests = 0;
  int     failed = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the DUT against the oldest prediction every cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("pc_hold",    32'(bus.pc_hold),    32'(e.pc_hold));
      cmp("ifid_flush", 32'(bus.ifid_flush), 32'(e.ifid_flush));
      cmp("ex_valid",   32'(bus.ex_valid),   32'(e.m.ev));
      cmp("ex_rw",      32'(bus.ex_rw),      32'(e.m.rw));
      cmp("ex_csrr",    32'(bus.ex_csrr),    32'(e.m.csrr));
      cmp("ex_wbsel",   32'(bus.ex_wbsel),   32'(e.m.wbsel));
      cmp("ex_pc",      bus.ex_pc,           e.m.pc);
      cmp("ex_a",       bus.ex_a,            e.m.a);
      cmp("ex_b",       bus.ex_b,            e.m.b);
      cmp("ex_c",       bus.ex_c,            e.m.c);
      cmp("ex_rd",      32'(bus.ex_rd),      32'(e.m.rd));
      cmp("ex_rs3",     32'(bus.ex_rs3),     32'(e.m.rs3));
      cmp("ex_aluop",   32'(bus.ex_aluop),   32'(e.m.aluop));
      cmp("bubble_cnt", bus.bubble_cnt,      e.m.cnt);
    end
  end

  function automatic stim_t quiet();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.id_valid = ($urandom_range(0, 9) < 8);
    s.pc     = $urandom;
    s.rs1    = 5'($urandom_range(0, 7));
    s.rs2    = 5'($urandom_range(0, 7));
    s.rs3    = 5'($urandom_range(0, 31));
    s.use_r1 = 1'($urandom);
    s.use_r2 = 1'($urandom);
    s.use_r3 = 1'($urandom);
    s.rd     = 5'($urandom_range(0, 7));
    s.rw     = 1'($urandom);
    s.csrr   = 1'($urandom);
    s.wbsel  = 2'($urandom);
    s.aluop  = 5'($urandom);
    s.fa     = $urandom;
    s.fb     = $urandom;
    s.fc     = $urandom;
    s.mrd    = 5'($urandom_range(0, 7));
    s.mrw    = 1'($urandom);
    s.mwbsel = 2'($urandom);
    s.flush  = ($urandom_range(0, 9) == 0);
    s.ext    = ($urandom_range(0, 6) == 0);
    return s;
  endfunction

  // Drive one cycle, predict the outputs seen before the next edge, advance the model.
  task automatic step(input stim_t s, input bit rst_low);
    exp_t e;
    bit   m1, m2, hz, ph, fl, cap, bub;
    @(posedge clk);
    #1;
    bus.id_valid = s.id_valid; bus.id_pc = s.pc;
    bus.id_rs1 = s.rs1; bus.id_rs2 = s.rs2; bus.id_rs3 = s.rs3;
    bus.id_use_r1 = s.use_r1; bus.id_use_r2 = s.use_r2; bus.id_use_r3 = s.use_r3;
    bus.id_rd = s.rd; bus.id_rw = s.rw; bus.id_csrr = s.csrr;
    bus.id_wbsel = s.wbsel; bus.id_aluop = s.aluop;
    bus.fwd_a = s.fa; bus.fwd_b = s.fb; bus.fwd_c = s.fc;
    bus.ex_mem_rd = s.mrd; bus.ex_mem_rw = s.mrw; bus.ex_mem_wbsel = s.mwbsel;
    bus.branch_flush = s.flush; bus.ext_stall = s.ext;
    rstn = !rst_low;
    if (rst_low) begin
      m = '{default: '0};
      e.pc_hold = 1'b0;
      e.ifid_flush = 1'b0;
      e.m = m;
      q.push_back(e);
    end else begin
      m1 = s.use_r1 && (s.rs1 != 0);
      m2 = s.use_r2 && (s.rs2 != 0);
      hz = s.id_valid &&
           ((m.ev && m.wbsel[0] && m.rw && ((m1 && s.rs1 == m.rd) || (m2 && s.rs2 == m.rd))) ||
            (s.mwbsel[0] && s.mrw && s.mrd != 0 &&
             ((m1 && s.rs1 == s.mrd) || (m2 && s.rs2 == s.mrd))));
      ph = 0; fl = 0; cap = 0; bub = 0;
      if (!m.held) begin
        if (s.ext) begin
          ph = 1; m.held = 1; m.pend = s.flush;
        end else if (s.flush) begin
          fl = 1; bub = 1;
        end else if (hz) begin
          ph = 1; bub = 1;
        end else begin
          cap = 1;
        end
      end else if (m.pend) begin
        if (!s.ext) begin
          fl = 1; bub = 1; m.held = 0; m.pend = 0;
        end else begin
          ph = 1;
        end
      end else begin
        ph = 1;
        if (s.flush) m.pend = 1;
        else if (!s.ext) m.held = 0;
      end
      e.pc_hold = ph;
      e.ifid_flush = fl;
      e.m = m;
      q.push_back(e);
      if (cap) begin
        m.ev = s.id_valid; m.rw = s.rw; m.csrr = s.csrr; m.wbsel = s.wbsel;
        m.pc = s.pc; m.a = s.fa; m.b = s.fb; m.c = s.fc;
        m.rd = s.rd; m.rs3 = s.rs3; m.aluop = s.aluop;
      end else if (bub) begin
        m.ev = 0; m.rw = 0; m.csrr = 0; m.wbsel = 2'b00;
        if (!s.flush || m.held || hz && !s.flush) m.cnt = m.cnt + (hz && !fl ? 32'd1 : 32'd0);
      end
    end
  endtask

  initial begin
    stim_t s, ld, dep;
    m = '{default: '0};
    bus.id_valid = 0; bus.branch_flush = 0; bus.ext_stall = 0;

    step(quiet(), 1'b1);
    step(quiet(), 1'b1);
    // Plain capture
    s = quiet(); s.id_valid = 1; s.rs1 = 5'd3; s.use_r1 = 1; s.fa = 32'h1234; s.pc = 32'h100;
    step(s, 1'b0);
    step(quiet(), 1'b0);
    // Load in ID/EX, dependent one slot behind
    ld = quiet(); ld.id_valid = 1; ld.rd = 5'd5; ld.rw = 1; ld.wbsel = 2'b01; ld.pc = 32'h200;
    step(ld, 1'b0);
    dep = quiet(); dep.id_valid = 1; dep.rs1 = 5'd5; dep.use_r1 = 1; dep.fa = 32'hABCD; dep.pc = 32'h204;
    step(dep, 1'b0);
    dep.mrd = 5'd5; dep.mrw = 1; dep.mwbsel = 2'b01;
    step(dep, 1'b0);
    dep.mrd = 5'd0; dep.mrw = 0; dep.mwbsel = 2'b00;
    step(dep, 1'b0);
    step(quiet(), 1'b0);
    // Load in EX/MEM, then the rd=0 variant
    s = quiet(); s.id_valid = 1; s.rs2 = 5'd7; s.use_r2 = 1; s.mrd = 5'd7; s.mrw = 1; s.mwbsel = 2'b01;
    step(s, 1'b0);
    s.mrd = 5'd0; s.rs2 = 5'd0;
    step(s, 1'b0);
    // Flush coincident with load stall
    s = quiet(); s.id_valid = 1; s.rs2 = 5'd7; s.use_r2 = 1; s.mrd = 5'd7; s.mrw = 1; s.mwbsel = 2'b01;
    s.flush = 1;
    step(s, 1'b0);
    // Valid instruction, then 3-cycle stall with flush in cycle 2
    s = quiet(); s.id_valid = 1; s.pc = 32'h300; s.fa = 32'h55; s.rw = 1; s.csrr = 1;
    step(s, 1'b0);
    s = quiet(); s.ext = 1; s.pc = 32'h304;
    step(s, 1'b0);
    s.flush = 1;
    step(s, 1'b0);
    s.flush = 0;
    step(s, 1'b0);
    step(quiet(), 1'b0);
    step(quiet(), 1'b0);
    // Reset while a flush is pending
    s = quiet(); s.ext = 1; s.flush = 1;
    step(s, 1'b0);
    s.flush = 0;
    step(s, 1'b0);
    step(s, 1'b1);
    step(quiet(), 1'b0);
    step(quiet(), 1'b0);
    // Randomized traffic with occasional reset
    for (int i = 0; i < 2000; i++) begin
      step(rand_stim(), ($urandom_range(0, 199) == 0));
    end
    step(quiet(), 1'b0);
    @(posedge clk);
    @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d predictions left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
